// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path and datapath muxes.
// MULTICYCLE_JAL_EN adds the JAL_EX state.
package mips_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMRD    = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWR    = 4'd5,
      S_RTYPE_EX = 4'd6,
      S_RTYPE_WB = 4'd7,
      S_BEQ_EX   = 4'd8,
      S_J_EX     = 4'd9,
      S_ADDI_EX  = 4'd10,
`ifdef MULTICYCLE_JAL_EN
      S_ADDI_WB  = 4'd11,
      S_JAL_EX   = 4'd12
`else
      S_ADDI_WB  = 4'd11
`endif
   } state_e;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [1:0] SRCB_B    = 2'b00;
   localparam logic [1:0] SRCB_4    = 2'b01;
   localparam logic [1:0] SRCB_IMM  = 2'b10;
   localparam logic [1:0] SRCB_IMM2 = 2'b11;

   localparam logic [1:0] PCS_ALU    = 2'b00;
   localparam logic [1:0] PCS_ALUOUT = 2'b01;
   localparam logic [1:0] PCS_JUMP   = 2'b10;

   localparam logic [1:0] RD_RT = 2'b00;
   localparam logic [1:0] RD_RD = 2'b01;
   localparam logic [1:0] RD_RA = 2'b10;

   localparam logic [1:0] MTR_ALUOUT = 2'b00;
   localparam logic [1:0] MTR_MDR    = 2'b01;
   localparam logic [1:0] MTR_PC     = 2'b10;

   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;

   typedef struct packed {
      logic       pc_write;
      logic       iord;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] pc_source;
      logic [1:0] reg_dst;
      logic [1:0] mem_to_reg;
      logic [1:0] alu_op;
   } ctrl_t;

endpackage

// File: rtl/ctrl_output_decode.sv
// State-to-control-word decode for multicycle_ctrl.
// MULTICYCLE_JAL_EN adds the JAL_EX control word.
module ctrl_output_decode
   import mips_ctrl_pkg::*;
(
   input  state_e state_i,
   input  logic   zero_i,
   input  logic   mem_ready_i,
   output ctrl_t  ctrl_o
);

   always_comb begin
      ctrl_o = '0;
      unique case (state_i)
         S_FETCH: begin
            ctrl_o.mem_read  = 1'b1;
            ctrl_o.alu_src_b = SRCB_4;
            ctrl_o.ir_write  = mem_ready_i;
            ctrl_o.pc_write  = mem_ready_i;
         end
         S_DECODE: ctrl_o.alu_src_b = SRCB_IMM2;
         S_MEMADR: begin
            ctrl_o.alu_src_a = 1'b1;
            ctrl_o.alu_src_b = SRCB_IMM;
         end
         S_MEMRD: begin
            ctrl_o.iord     = 1'b1;
            ctrl_o.mem_read = 1'b1;
         end
         S_MEMWB: begin
            ctrl_o.reg_write  = 1'b1;
            ctrl_o.mem_to_reg = MTR_MDR;
         end
         S_MEMWR: begin
            ctrl_o.iord      = 1'b1;
            ctrl_o.mem_write = 1'b1;
         end
         S_RTYPE_EX: begin
            ctrl_o.alu_src_a = 1'b1;
            ctrl_o.alu_op    = ALU_FUNCT;
         end
         S_RTYPE_WB: begin
            ctrl_o.reg_write = 1'b1;
            ctrl_o.reg_dst   = RD_RD;
         end
         // Branch commit follows Zero in the same cycle.
         S_BEQ_EX: begin
            ctrl_o.alu_src_a = 1'b1;
            ctrl_o.alu_op    = ALU_SUB;
            ctrl_o.pc_source = PCS_ALUOUT;
            ctrl_o.pc_write  = zero_i;
         end
         S_J_EX: begin
            ctrl_o.pc_source = PCS_JUMP;
            ctrl_o.pc_write  = 1'b1;
         end
         S_ADDI_EX: begin
            ctrl_o.alu_src_a = 1'b1;
            ctrl_o.alu_src_b = SRCB_IMM;
         end
         S_ADDI_WB: ctrl_o.reg_write = 1'b1;
`ifdef MULTICYCLE_JAL_EN
         S_JAL_EX: begin
            ctrl_o.reg_write  = 1'b1;
            ctrl_o.reg_dst    = RD_RA;
            ctrl_o.mem_to_reg = MTR_PC;
            ctrl_o.pc_source  = PCS_JUMP;
            ctrl_o.pc_write   = 1'b1;
         end
`endif
         default: ctrl_o = '0;
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS datapath with memory stall timeout.
// MULTICYCLE_JAL_EN enables the jal instruction.
module multicycle_ctrl
   import mips_ctrl_pkg::*;
#(
   parameter int MEM_WAIT_MAX = 15
) (
   input  logic       CLK,
   input  logic       Reset,
   input  logic [5:0] Opcode,
   input  logic       Zero,
   input  logic       MemReady,
   output logic       PCWrite,
   output logic       IorD,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       RegWrite,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] PCSource,
   output logic [1:0] RegDst,
   output logic [1:0] MemtoReg,
   output logic [1:0] ALUOp,
   output logic [3:0] State,
   output logic       IllegalOp,
   output logic       MemTimeout
);

   localparam int CW = $clog2(MEM_WAIT_MAX + 1);

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          stall, timeout, illegal;
   ctrl_t         ctrl, ctrl_g;

   always_ff @(posedge CLK) begin
      if (Reset) begin
         state_q <= S_FETCH;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      stall   = (state_q inside {S_FETCH, S_MEMRD, S_MEMWR}) && !MemReady;
      timeout = stall && (cnt_q == CW'(MEM_WAIT_MAX));
      illegal = 1'b0;
      state_d = state_q;
      unique case (state_q)
         S_FETCH: if (MemReady) state_d = S_DECODE;
         S_DECODE: begin
            unique case (Opcode)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_RTYPE:     state_d = S_RTYPE_EX;
               OP_BEQ:       state_d = S_BEQ_EX;
               OP_J:         state_d = S_J_EX;
               OP_ADDI:      state_d = S_ADDI_EX;
`ifdef MULTICYCLE_JAL_EN
               OP_JAL:       state_d = S_JAL_EX;
`endif
               default: begin
                  illegal = 1'b1;
                  state_d = S_FETCH;
               end
            endcase
         end
         S_MEMADR:   state_d = (Opcode == OP_SW) ? S_MEMWR : S_MEMRD;
         S_MEMRD:    if (MemReady) state_d = S_MEMWB;
         S_MEMWR:    if (MemReady) state_d = S_FETCH;
         S_RTYPE_EX: state_d = S_RTYPE_WB;
         S_ADDI_EX:  state_d = S_ADDI_WB;
         default:    state_d = S_FETCH;
      endcase
      if (timeout) state_d = S_FETCH;
      // A timeout re-enters FETCH, which also counts as a state entry.
      cnt_d = cnt_q;
      if (timeout || state_d != state_q) cnt_d = '0;
      else if (stall) cnt_d = cnt_q + CW'(1);
   end

   ctrl_output_decode u_dec (
      .state_i     (state_q),
      .zero_i      (Zero),
      .mem_ready_i (MemReady),
      .ctrl_o      (ctrl)
   );

   always_comb begin
      ctrl_g = Reset ? '0 : ctrl;
   end

   assign PCWrite    = ctrl_g.pc_write;
   assign IorD       = ctrl_g.iord;
   assign MemRead    = ctrl_g.mem_read;
   assign MemWrite   = ctrl_g.mem_write;
   assign IRWrite    = ctrl_g.ir_write;
   assign RegWrite   = ctrl_g.reg_write;
   assign ALUSrcA    = ctrl_g.alu_src_a;
   assign ALUSrcB    = ctrl_g.alu_src_b;
   assign PCSource   = ctrl_g.pc_source;
   assign RegDst     = ctrl_g.reg_dst;
   assign MemtoReg   = ctrl_g.mem_to_reg;
   assign ALUOp      = ctrl_g.alu_op;
   assign State      = Reset ? 4'd0 : state_q;
   assign IllegalOp  = illegal && !Reset;
   assign MemTimeout = timeout && !Reset;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed scoreboard bench for multicycle_ctrl.
// Honours MULTICYCLE_JAL_EN for the opcode 0x03 case.
module tb_multicycle_ctrl;

   logic       CLK = 1'b0;
   logic       Reset, Zero, MemReady;
   logic [5:0] Opcode;
   logic       PCWrite, IorD, MemRead, MemWrite, IRWrite, RegWrite, ALUSrcA;
   logic [1:0] ALUSrcB, PCSource, RegDst, MemtoReg, ALUOp;
   logic [3:0] State;
   logic       IllegalOp, MemTimeout;

   int checks = 0;
   int failures = 0;
   logic [22:0] sb[$];

   always #5 CLK = ~CLK;

   multicycle_ctrl #(.MEM_WAIT_MAX(15)) dut (
      .CLK(CLK), .Reset(Reset), .Opcode(Opcode), .Zero(Zero),
      .MemReady(MemReady), .PCWrite(PCWrite), .IorD(IorD),
      .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
      .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
      .PCSource(PCSource), .RegDst(RegDst), .MemtoReg(MemtoReg),
      .ALUOp(ALUOp), .State(State), .IllegalOp(IllegalOp),
      .MemTimeout(MemTimeout)
   );

   // {State, PCWrite,IorD,MemRead,MemWrite,IRWrite,RegWrite,ALUSrcA,
   //  ALUSrcB, PCSource, RegDst, MemtoReg, ALUOp, IllegalOp, MemTimeout}
   function automatic logic [22:0] v(
      input logic [3:0] st, input logic [6:0] stb,
      input logic [1:0] asb, pcs, rdst, mtr, aop,
      input logic ill, tmo);
      return {st, stb, asb, pcs, rdst, mtr, aop, ill, tmo};
   endfunction

   function automatic logic [22:0] obs();
      return {State, PCWrite, IorD, MemRead, MemWrite, IRWrite, RegWrite,
              ALUSrcA, ALUSrcB, PCSource, RegDst, MemtoReg, ALUOp,
              IllegalOp, MemTimeout};
   endfunction

   task automatic chk(input string tag);
      logic [22:0] e, o;
      checks++;
      if (sb.size() == 0) begin
         failures++;
         $error("FAIL %s scoreboard empty", tag);
      end else begin
         e = sb.pop_front();
         o = obs();
         assert (o === e) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
         end
      end
   endtask

   task automatic step(input string tag, input logic rst, rdy, z,
                       input logic [5:0] op, input logic [22:0] e);
      Reset = rst; MemReady = rdy; Zero = z; Opcode = op;
      sb.push_back(e);
      @(negedge CLK);
      chk(tag);
      @(posedge CLK);
      #1;
   endtask

   logic [22:0] ZERO, F_RDY, F_WAIT, F_TMO, DEC, DEC_ILL, MADR, MRD, MWB;
   logic [22:0] MWR, REX, RWB, BEQ1, BEQ0, JEX, AEX, AWB, JAL;

   initial begin
      ZERO    = '0;
      F_RDY   = v(4'd0, 7'b1010100, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0);
      F_WAIT  = v(4'd0, 7'b0010000, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0);
      F_TMO   = v(4'd0, 7'b0010000, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 0, 1);
      DEC     = v(4'd1, 7'b0000000, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0);
      DEC_ILL = v(4'd1, 7'b0000000, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0);
      MADR    = v(4'd2, 7'b0000001, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0);
      MRD     = v(4'd3, 7'b0110000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0);
      MWB     = v(4'd4, 7'b0000010, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 0, 0);
      MWR     = v(4'd5, 7'b0101000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0);
      REX     = v(4'd6, 7'b0000001, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 0, 0);
      RWB     = v(4'd7, 7'b0000010, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 0, 0);
      BEQ1    = v(4'd8, 7'b1000001, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01, 0, 0);
      BEQ0    = v(4'd8, 7'b0000001, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01, 0, 0);
      JEX     = v(4'd9, 7'b1000000, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 0, 0);
      AEX     = v(4'd10, 7'b0000001, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0);
      AWB     = v(4'd11, 7'b0000010, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0);
      JAL     = v(4'd12, 7'b1000010, 2'b00, 2'b10, 2'b10, 2'b10, 2'b00, 0, 0);

      for (int i = 0; i < 3; i++) step("reset", 1, 1, 1, 6'h23, ZERO);

      step("lw_f", 0, 1, 0, 6'h23, F_RDY);
      step("lw_d", 0, 1, 0, 6'h23, DEC);
      step("lw_a", 0, 1, 0, 6'h23, MADR);
      step("lw_r", 0, 1, 0, 6'h23, MRD);
      step("lw_wb", 0, 1, 0, 6'h23, MWB);

      step("beq1_f", 0, 1, 1, 6'h04, F_RDY);
      step("beq1_d", 0, 1, 1, 6'h04, DEC);
      step("beq1_ex", 0, 1, 1, 6'h04, BEQ1);
      step("beq0_f", 0, 1, 0, 6'h04, F_RDY);
      step("beq0_d", 0, 1, 0, 6'h04, DEC);
      step("beq0_ex", 0, 1, 0, 6'h04, BEQ0);

      step("sw_f", 0, 1, 0, 6'h2B, F_RDY);
      step("sw_d", 0, 0, 0, 6'h2B, DEC);
      step("sw_a", 0, 0, 0, 6'h2B, MADR);
      for (int i = 0; i < 4; i++) step("sw_wait", 0, 0, 0, 6'h2B, MWR);
      step("sw_done", 0, 1, 0, 6'h2B, MWR);

      step("r_f", 0, 1, 0, 6'h00, F_RDY);
      step("r_d", 0, 1, 0, 6'h00, DEC);
      step("r_ex", 0, 1, 0, 6'h00, REX);
      step("r_wb", 0, 1, 0, 6'h00, RWB);

      step("addi_f", 0, 1, 0, 6'h08, F_RDY);
      step("addi_d", 0, 1, 0, 6'h08, DEC);
      step("addi_ex", 0, 1, 0, 6'h08, AEX);
      step("addi_wb", 0, 1, 0, 6'h08, AWB);

      step("j_f", 0, 1, 0, 6'h02, F_RDY);
      step("j_d", 0, 1, 0, 6'h02, DEC);
      step("j_ex", 0, 1, 1, 6'h02, JEX);

      step("bad_f", 0, 1, 0, 6'h3F, F_RDY);
      step("bad_d", 0, 1, 0, 6'h3F, DEC_ILL);

      for (int i = 0; i < 15; i++) step("tmo_wait", 0, 0, 0, 6'h03, F_WAIT);
      step("tmo_pulse", 0, 0, 0, 6'h03, F_TMO);
      for (int i = 0; i < 15; i++) step("tmo_wait2", 0, 0, 0, 6'h03, F_WAIT);
      step("ready_wins", 0, 1, 0, 6'h03, F_RDY);
`ifdef MULTICYCLE_JAL_EN
      step("jal_d", 0, 1, 0, 6'h03, DEC);
      step("jal_ex", 0, 1, 0, 6'h03, JAL);
`else
      step("op03_d", 0, 1, 0, 6'h03, DEC_ILL);
`endif
      step("op03_next", 0, 1, 0, 6'h23, F_RDY);

      step("abort_d", 0, 1, 0, 6'h23, DEC);
      step("abort_rst", 1, 1, 0, 6'h23, ZERO);
      step("abort_f", 0, 0, 0, 6'h23, F_WAIT);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
